icache_direct_mapped: RTL
=========================

Name: icache_direct_mapped

Overview:
- Blocking, read-only, direct-mapped instruction cache with 256-bit (32-byte) lines.
- Sits between the fetch stage (upstream) and the I-side of the cacheline adaptor (downstream).
- Serves 32-bit instruction fetches; hits respond one cycle after the request.
- Misses issue one full-line read to the adaptor, install the line, then respond.
- A kill input discards in-flight fetches on redirect without aborting an adaptor transaction.

Parameters:
- SETS, 16, number of lines; power of two, 2..256. IDX_W = log2(SETS); TAG_W = 27 - IDX_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- ufp_read  input  1  fetch request pulse; legal only when state is IDLE or ufp_resp is high this cycle
- ufp_addr  input  32  fetch byte address; bits [1:0] must be 00; sampled only when ufp_read is accepted
- kill  input  1  discard any fetch accepted before this cycle
- ufp_rdata  output  32  instruction word; valid only while ufp_resp is high
- ufp_resp  output  1  one-cycle response strobe
- dfp_addr  output  32  line address {tag, index, 5'b0}
- dfp_read  output  1  line read request; held high until dfp_resp
- dfp_rdata  input  256  line data; bits [32k+31:32k] hold word k
- dfp_resp  input  1  one-cycle fill-complete strobe

Behaviour:
- Storage, all flops: valid[SETS], tag[SETS][TAG_W], data[SETS][256]. Reads are combinational on the latched address.
- Address split: offset = addr[4:0], word = addr[4:2], index = addr[5 +: IDX_W], tag = addr[31 -: TAG_W].
- Registered state: state (IDLE, LOOKUP, FILL), req_addr[31:0], drop (1 bit).
- Reset: state = IDLE, all valid = 0, drop = 0, req_addr = 0. Outputs in reset: ufp_resp = 0, dfp_read = 0, dfp_addr = 0, ufp_rdata = 0.
- IDLE:
  - If ufp_read is high: req_addr <= ufp_addr, drop <= 0, next state = LOOKUP.
  - Otherwise stay in IDLE.
  - kill has no effect in IDLE.
- LOOKUP: hit = valid[index] && tag[index] == req tag.
  - kill high: no ufp_resp. Next state is LOOKUP if ufp_read is high (new address latched), else IDLE.
  - Hit and no kill: ufp_resp = 1, ufp_rdata = data[index][32*word +: 32]. If ufp_read is high in the same cycle, latch the new address and stay in LOOKUP (back-to-back hits, one per cycle). Else go to IDLE.
  - Miss and no kill: next state = FILL.
- FILL:
  - dfp_read = 1; dfp_addr = {req_addr[31:5], 5'b0}, held constant every cycle until dfp_resp, because the adaptor matches the returned address against it.
  - kill during FILL: set drop = 1. The fill is never aborted.
  - On dfp_resp: write data[index] = dfp_rdata, tag[index] = req tag, valid[index] = 1 at that clock edge.
  - After dfp_resp, next state = LOOKUP if no kill this cycle and drop == 0. Otherwise next state = IDLE and drop <= 0.
  - ufp_read arriving during FILL is illegal; the design ignores it and asserts in simulation.
- Latency:
  - Hit: request at cycle T gives ufp_resp at T+1.
  - Miss: dfp_read rises at T+2. With dfp_resp at F, ufp_resp comes at F+1 from the now-valid line.
- Simultaneous kill and dfp_resp: the line is installed and no ufp_resp is given.
- dfp_read is 0 in every state except FILL.
- Outside FILL, dfp_addr = 0.
- When ufp_resp is low, ufp_rdata = 0.
- Reset mid-FILL: return to IDLE and invalidate everything. The adaptor shares rst, so no stale dfp_resp is expected.
- No write path; the lines are never dirty.

Test Plan:
- Cold miss:
  - Stimulus: reset, then ufp_read with addr 0x0000_1044; model returns a line with word k = 0xA000_0000+k, dfp_resp 5 cycles after dfp_read.
  - Required: dfp_read goes high with dfp_addr 0x0000_1040; ufp_resp arrives 1 cycle after dfp_resp with ufp_rdata 0xA000_0001.
- Back-to-back hits:
  - Stimulus: after the cold miss, ufp_read 0x1040, 0x1048, 0x105C on consecutive cycles.
  - Required: three consecutive ufp_resp with 0xA000_0000, 0xA000_0002, 0xA000_0007; dfp_read stays 0.
- Conflict eviction, SETS = 16:
  - Stimulus: fill 0x0000_1040 and then fetch 0x0000_1240 (same index 2, different tag).
  - Required: a miss with dfp_addr 0x1240; a re-fetch of 0x1044 then misses again.
- Kill during FILL:
  - Stimulus: miss on 0x2000, pulse kill 2 cycles into FILL.
  - Required: dfp_read stays high until dfp_resp; no ufp_resp; state returns to IDLE; a later fetch of 0x2000 hits at T+1.
- Kill in LOOKUP with a new request in the same cycle:
  - Stimulus: hit fetch of 0x1040 killed in its LOOKUP cycle while ufp_read 0x1048 is high.
  - Required: no response for 0x1040; next cycle ufp_resp with word 2.
- Reset mid-FILL:
  - Stimulus: assert rst while dfp_read is high.
  - Required: the next cycle has dfp_read = 0 and ufp_resp = 0; a fetch of a previously cached address misses.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// Blocking read-only direct-mapped instruction cache, 256-bit lines, flop storage.
// One fetch in flight; misses pull a full line from the cacheline adaptor.
module icache_direct_mapped #(
    parameter int SETS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ufp_read,
    input  logic [31:0]  ufp_addr,
    input  logic         kill,
    output logic [31:0]  ufp_rdata,
    output logic         ufp_resp,
    output logic [31:0]  dfp_addr,
    output logic         dfp_read,
    input  logic [255:0] dfp_rdata,
    input  logic         dfp_resp
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    state_t             state;
    state_t             next_state;
    logic [31:0]        req_addr;
    logic               drop;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags  [SETS];
    logic [255:0]       lines [SETS];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         word;
    logic               hit;
    logic               latch;
    logic               install;

    assign idx     = req_addr[5 +: IDX_W];
    assign req_tag = req_addr[31 -: TAG_W];
    assign word    = req_addr[4:2];
    assign hit     = valid[idx] && (tags[idx] == req_tag);

    // A new address is taken from IDLE, or from LOOKUP once the current fetch is done or killed.
    assign latch   = ufp_read && ((state == IDLE) || ((state == LOOKUP) && (kill || hit)));
    assign install = (state == FILL) && dfp_resp;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ufp_read) next_state = LOOKUP;
            LOOKUP: begin
                if (kill || hit) next_state = ufp_read ? LOOKUP : IDLE;
                else             next_state = FILL;
            end
            FILL: begin
                if (dfp_resp) next_state = (!kill && !drop) ? LOOKUP : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ufp_resp  = 1'b0;
        ufp_rdata = '0;
        dfp_read  = 1'b0;
        dfp_addr  = '0;
        if (!rst) begin
            case (state)
                LOOKUP: begin
                    if (hit && !kill) begin
                        ufp_resp  = 1'b1;
                        ufp_rdata = lines[idx][{word, 5'b00000} +: 32];
                    end
                end
                FILL: begin
                    dfp_read = 1'b1;
                    dfp_addr = {req_addr[31:5], 5'b00000};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr <= '0;
            drop     <= 1'b0;
            valid    <= '0;
        end else begin
            if (latch) begin
                req_addr <= ufp_addr;
                drop     <= 1'b0;
            end
            // A kill cannot abort the adaptor, so remember it until the fill lands.
            if (state == FILL) begin
                if (dfp_resp) begin
                    valid[idx] <= 1'b1;
                    drop       <= 1'b0;
                end else if (kill) begin
                    drop <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tags[idx]  <= req_tag;
            lines[idx] <= dfp_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == FILL)   assert (!ufp_read);
        if (!rst && state == LOOKUP) assert (req_addr[1:0] == 2'b00);
    end
endmodule
